// File: rtl/prim_arbiter_pkt_pkg.sv
// Shared types for the packet-aware round-robin arbiter.
package prim_arbiter_pkt_pkg;

  // IDLE: no owner, arbitrate every cycle. LOCKED: idx register owns the output.
  typedef enum logic {
    ArbIdle   = 1'b0,
    ArbLocked = 1'b1
  } arb_state_e;

endpackage

// File: rtl/prim_arbiter_pkt_pick.sv
// Masked-priority pick: lowest set bit of (valid & mask) if any, else lowest
// set bit of valid. Uses a prefix-OR chain whose XOR with its own shifted copy
// isolates the first set bit; the same finder is built twice.
module prim_arbiter_pkt_pick
  import prim_arbiter_pkt_pkg::*;
#(
  parameter  int N    = 4,
  localparam int IdxW = $clog2(N)
) (
  input  logic [N-1:0]    valid,
  input  logic [N-1:0]    mask,
  output logic [N-1:0]    onehot,
  output logic [IdxW-1:0] idx
);

  logic [N-1:0] masked;
  logic [N-1:0] pre_m;
  logic [N-1:0] pre_u;
  logic [N-1:0] oh_m;
  logic [N-1:0] oh_u;

  assign masked   = valid & mask;
  assign pre_m[0] = masked[0];
  assign pre_u[0] = valid[0];

  for (genvar gi = 1; gi < N; gi++) begin : g_prefix
    assign pre_m[gi] = pre_m[gi-1] | masked[gi];
    assign pre_u[gi] = pre_u[gi-1] | valid[gi];
  end

  assign oh_m = pre_m ^ {pre_m[N-2:0], 1'b0};
  assign oh_u = pre_u ^ {pre_u[N-2:0], 1'b0};

  // Masked candidates take precedence; the top prefix bit says whether any exist.
  assign onehot = pre_m[N-1] ? oh_m : oh_u;

  // Encode the one-hot winner into an index (zero when nobody is valid).
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) idx = idx | IdxW'(i);
    end
  end

endmodule

// File: rtl/prim_arbiter_pkt.sv
// Packet-aware round-robin arbiter: one valid/ready output shared by N
// requesters. A winner keeps the grant until its last beat is accepted, or
// until it hits MaxBeats beats, in which case it is released with an err pulse.
module prim_arbiter_pkt
  import prim_arbiter_pkt_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int DW       = 32,
  parameter  int MaxBeats = 16,
  localparam int IdxW     = $clog2(N)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    in_valid_i,
  input  logic [N*DW-1:0] in_data_i,
  input  logic [N-1:0]    in_last_i,
  output logic [N-1:0]    in_ready_o,
  output logic            out_valid_o,
  output logic [DW-1:0]   out_data_o,
  output logic            out_last_o,
  output logic [IdxW-1:0] out_idx_o,
  input  logic            out_ready_i,
  output logic            err_o
);

  localparam int            BW        = $clog2(MaxBeats + 1);
  localparam logic [BW-1:0] MaxBeatsB = BW'(MaxBeats);

  arb_state_e    state_reg, state_next;
  logic [IdxW-1:0] idx_reg, idx_next;
  logic [N-1:0]  mask_reg, mask_next;
  logic [BW-1:0] beat_reg, beat_next;
  logic          err_reg, err_next;

  logic [N-1:0]    pick_onehot;
  logic [IdxW-1:0] pick_idx;
  logic [N-1:0]    owner_onehot;
  logic [IdxW-1:0] owner_idx;
  logic [N-1:0]    above_mask;
  logic [DW-1:0]   data_mux;
  logic            valid_mux;
  logic            last_mux;
  logic            hs;
  logic            release_now;
  logic [BW-1:0]   beat_inc;

  prim_arbiter_pkt_pick #(
    .N(N)
  ) u_pick (
    .valid  (in_valid_i),
    .mask   (mask_reg),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  // Current owner: the locked index, or this cycle's arbitration winner.
  always_comb begin
    owner_onehot = '0;
    owner_idx    = pick_idx;
    if (state_reg == ArbLocked) begin
      owner_onehot[idx_reg] = 1'b1;
      owner_idx             = idx_reg;
    end else begin
      owner_onehot = pick_onehot;
    end
  end

  // Round-robin pointer: requesters strictly above the owner get priority next.
  for (genvar gi = 0; gi < N; gi++) begin : g_above
    assign above_mask[gi] = (IdxW'(gi) > owner_idx);
  end

  // AND-OR output mux over the one-hot owner.
  always_comb begin
    data_mux = '0;
    for (int i = 0; i < N; i++) begin
      data_mux = data_mux | (in_data_i[i*DW +: DW] & {DW{owner_onehot[i]}});
    end
  end

  assign valid_mux   = |(in_valid_i & owner_onehot);
  assign last_mux    = |(in_last_i & owner_onehot);
  assign hs          = valid_mux & out_ready_i;
  assign beat_inc    = beat_reg + BW'(1);
  assign release_now = hs & (last_mux | (beat_inc == MaxBeatsB));

  assign out_valid_o = valid_mux & ~rst_i;
  assign in_ready_o  = owner_onehot & {N{out_ready_i & ~rst_i}};
  assign out_data_o  = rst_i ? '0 : data_mux;
  assign out_last_o  = last_mux & ~rst_i;
  assign out_idx_o   = rst_i ? '0 : owner_idx;
  assign err_o       = err_reg;

  // Grant FSM: lock on any presented beat, release on last or beat overrun.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    mask_next  = mask_reg;
    beat_next  = beat_reg;
    err_next   = 1'b0;
    unique case (state_reg)
      ArbIdle: begin
        if (release_now) begin
          // Single-beat packet, or overrun on the first beat when MaxBeats=1.
          mask_next = above_mask;
          beat_next = '0;
          err_next  = ~last_mux;
        end else if (valid_mux) begin
          // Stalled or accepted non-last beat: grant must not move.
          state_next = ArbLocked;
          idx_next   = owner_idx;
          beat_next  = hs ? BW'(1) : '0;
        end
      end
      ArbLocked: begin
        if (release_now) begin
          state_next = ArbIdle;
          mask_next  = above_mask;
          beat_next  = '0;
          err_next   = ~last_mux;
        end else if (hs) begin
          beat_next = beat_inc;
        end
      end
      default: state_next = ArbIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ArbIdle;
      idx_reg   <= '0;
      mask_reg  <= '0;
      beat_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      mask_reg  <= mask_next;
      beat_reg  <= beat_next;
      err_reg   <= err_next;
    end
  end

endmodule

// File: tb/tb_prim_arbiter_pkt.sv
// Directed bench for prim_arbiter_pkt (N=4, DW=32, MaxBeats=4).
module tb_prim_arbiter_pkt;

  localparam int N  = 4;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic [N-1:0]  in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]  in_last;
  logic [N-1:0]  in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [1:0]    out_idx;
  logic          out_ready;
  logic          err;

  int checks   = 0;
  int failures = 0;

  prim_arbiter_pkt #(
    .N(N), .DW(DW), .MaxBeats(4)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_last_i  (in_last),
    .in_ready_o (in_ready),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .out_last_o (out_last),
    .out_idx_o  (out_idx),
    .out_ready_i(out_ready),
    .err_o      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dat(input int i, input int b);
    return {16'hD0A0, 8'(i), 8'(b)};
  endfunction

  task automatic set_data(input int i, input int b);
    in_data[i*DW +: DW] = dat(i, b);
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic rdy);
    in_valid  = v;
    in_last   = l;
    out_ready = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One line per accepted beat.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready)
      $display("beat req=%0d data=%08h last=%0b err=%0b", out_idx, out_data, out_last, err);
  end

  int exp1[4] = '{1, 3, 1, 3};

  initial begin
    rst = 1'b1;
    in_data = '0;
    for (int i = 0; i < N; i++) set_data(i, 0);
    drive(4'b1111, 4'b1111, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 0);
    check("rst_data", out_data, 0);
    check("rst_last", out_last, 0);
    check("rst_idx", out_idx, 0);
    check("rst_err", err, 0);
    next_cycle();
    rst = 1'b0;

    // Single-beat packets from req1 and req3: strict alternation, no bubbles.
    for (int k = 0; k < 4; k++) begin
      drive(4'b1010, 4'b1111, 1'b1);
      @(negedge clk);
      check("rr_idx", out_idx, exp1[k]);
      check("rr_valid", out_valid, 1);
      check("rr_ready", in_ready, 64'(1) << exp1[k]);
      check("rr_data", out_data, dat(exp1[k], 0));
      next_cycle();
    end

    // Req0 3-beat packet holds the grant against req2.
    for (int b = 0; b < 3; b++) begin
      set_data(0, b);
      drive(4'b0101, (b == 2) ? 4'b0001 : 4'b0000, 1'b1);
      @(negedge clk);
      check("pkt_idx", out_idx, 0);
      check("pkt_ready", in_ready, 4'b0001);
      check("pkt_data", out_data, dat(0, b));
      check("pkt_last", out_last, (b == 2));
      next_cycle();
    end
    set_data(2, 0);
    drive(4'b0100, 4'b0100, 1'b1);
    @(negedge clk);
    check("pkt_next_idx", out_idx, 2);
    check("pkt_next_ready", in_ready, 4'b0100);
    next_cycle();

    // Stalled first beat of req1 locks the grant while req0 appears.
    set_data(1, 7);
    drive(4'b0010, 4'b0010, 1'b0);
    @(negedge clk);
    check("stall_valid", out_valid, 1);
    check("stall_idx0", out_idx, 1);
    check("stall_ready0", in_ready, 0);
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      drive(4'b0011, 4'b0011, 1'b0);
      @(negedge clk);
      check("stall_idx", out_idx, 1);
      check("stall_data", out_data, dat(1, 7));
      check("stall_ready", in_ready, 0);
      next_cycle();
    end
    drive(4'b0011, 4'b0011, 1'b1);
    @(negedge clk);
    check("stall_hs_idx", out_idx, 1);
    check("stall_hs_ready", in_ready, 4'b0010);
    next_cycle();

    // Req3 overruns MaxBeats=4; req0 is valid throughout.
    for (int b = 0; b < 4; b++) begin
      set_data(3, b);
      drive(4'b1001, 4'b0000, 1'b1);
      @(negedge clk);
      check("ovr_idx", out_idx, 3);
      check("ovr_ready", in_ready, 4'b1000);
      check("ovr_err_lo", err, 0);
      next_cycle();
    end
    set_data(3, 4);
    set_data(0, 0);
    drive(4'b1001, 4'b0001, 1'b1);
    @(negedge clk);
    check("ovr_err_hi", err, 1);
    check("ovr_next_idx", out_idx, 0);
    check("ovr_next_ready", in_ready, 4'b0001);
    next_cycle();
    drive(4'b1000, 4'b1000, 1'b1);
    @(negedge clk);
    check("ovr_err_pulse", err, 0);
    check("ovr_resume_idx", out_idx, 3);
    check("ovr_resume_data", out_data, dat(3, 4));
    next_cycle();

    // Reset during req2's second beat clears the lock and the pointer.
    set_data(2, 0);
    drive(4'b0100, 4'b0000, 1'b1);
    @(negedge clk);
    check("mrst_idx", out_idx, 2);
    next_cycle();
    set_data(2, 1);
    rst = 1'b1;
    drive(4'b0101, 4'b0000, 1'b1);
    @(negedge clk);
    check("mrst_valid", out_valid, 0);
    check("mrst_ready", in_ready, 0);
    check("mrst_data", out_data, 0);
    next_cycle();
    rst = 1'b0;
    drive(4'b0101, 4'b0101, 1'b1);
    @(negedge clk);
    check("mrst_after_idx", out_idx, 0);
    check("mrst_after_ready", in_ready, 4'b0001);
    check("mrst_err", err, 0);
    next_cycle();
    drive(4'b0100, 4'b0100, 1'b1);
    @(negedge clk);
    check("mrst_req2_idx", out_idx, 2);
    check("mrst_err2", err, 0);
    next_cycle();

    // Owner req1 drops valid mid-packet; req0 must not steal the output.
    set_data(1, 0);
    drive(4'b0010, 4'b0000, 1'b1);
    @(negedge clk);
    check("gap_idx0", out_idx, 1);
    check("gap_ready0", in_ready, 4'b0010);
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      drive(4'b0001, 4'b0001, 1'b1);
      @(negedge clk);
      check("gap_valid", out_valid, 0);
      check("gap_idx", out_idx, 1);
      check("gap_ready", in_ready, 4'b0010);
      next_cycle();
    end
    set_data(1, 1);
    drive(4'b0011, 4'b0011, 1'b1);
    @(negedge clk);
    check("gap_resume_valid", out_valid, 1);
    check("gap_resume_idx", out_idx, 1);
    check("gap_resume_data", out_data, dat(1, 1));
    check("gap_resume_last", out_last, 1);
    next_cycle();
    drive(4'b0001, 4'b0001, 1'b1);
    @(negedge clk);
    check("gap_next_idx", out_idx, 0);
    check("gap_next_ready", in_ready, 4'b0001);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
